// File: rtl/dreg_universal.sv
// Universal WIDTH-bit D register: hold, parallel load, shift left/right with
// serial fill or rotate, synchronous clear, plus complement and zero outputs.
module dreg_universal #(
  parameter int unsigned      WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             input_clock1_clk_1,
  input  logic             input_push_button2_rst_n_2,
  input  logic             input_push_button3_clr_3,
  input  logic [1:0]       input_switch4_mode_4,
  input  logic             input_push_button5_rot_5,
  input  logic             input_push_button6_sin_l_6,
  input  logic             input_push_button7_sin_r_7,
  input  logic [WIDTH-1:0] input_switch8_d_8,
  output logic [WIDTH-1:0] output_led1_q_0_9,
  output logic [WIDTH-1:0] output_led2_qn_0_10,
  output logic             output_led3_zero_11
);

  localparam logic [1:0] ModeHold  = 2'b00;
  localparam logic [1:0] ModeShl   = 2'b01;
  localparam logic [1:0] ModeShr   = 2'b10;
  localparam logic [1:0] ModeLoad  = 2'b11;

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] shl_val, shr_val;

  // Shifted candidates; a 1-bit register has no neighbours, so rotate holds
  // and serial fill simply takes the incoming bit.
  if (WIDTH == 1) begin : g_w1
    assign shl_val = input_push_button5_rot_5 ? q_q : input_push_button7_sin_r_7;
    assign shr_val = input_push_button5_rot_5 ? q_q : input_push_button6_sin_l_6;
  end else begin : g_wn
    assign shl_val = {q_q[WIDTH-2:0],
                      input_push_button5_rot_5 ? q_q[WIDTH-1] : input_push_button7_sin_r_7};
    assign shr_val = {input_push_button5_rot_5 ? q_q[0] : input_push_button6_sin_l_6,
                      q_q[WIDTH-1:1]};
  end

  // Next-state selection: clear wins over every mode.
  always_comb begin
    q_d = q_q;
    if (input_push_button3_clr_3) begin
      q_d = RESET_VALUE;
    end else begin
      unique case (input_switch4_mode_4)
        ModeHold: q_d = q_q;
        ModeShl:  q_d = shl_val;
        ModeShr:  q_d = shr_val;
        ModeLoad: q_d = input_switch8_d_8;
        default:  q_d = q_q;
      endcase
    end
  end

  // Register bank with asynchronous active-low reset.
  always_ff @(posedge input_clock1_clk_1 or negedge input_push_button2_rst_n_2) begin
    if (!input_push_button2_rst_n_2) begin
      q_q <= RESET_VALUE;
    end else begin
      q_q <= q_d;
    end
  end

  // Outputs are pure functions of the stored value.
  always_comb begin
    output_led1_q_0_9   = q_q;
    output_led2_qn_0_10 = ~q_q;
    output_led3_zero_11 = (q_q == '0);
  end

endmodule
